// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Control side of the EX-stage operand-forwarding muxes. It keeps its own shadow
// copy of the ID/EX, EX/MEM and MEM/WB destination information. From that it
// produces the operand-A/B forward selects, a load-use stall request and a
// saturating count of stalled cycles.
module fwd_hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  id_rt_used_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_regwrite_i,
   input  logic                  id_memread_i,
   input  logic                  flush_i,
   output logic [1:0]            fwd_a_o,
   output logic [1:0]            fwd_b_o,
   output logic                  stall_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   localparam logic [1:0] SEL_REGFILE = 2'd0;
   localparam logic [1:0] SEL_MEMWB   = 2'd1;
   localparam logic [1:0] SEL_EXMEM   = 2'd2;

   // ID/EX shadow stage
   logic [REG_ADDR_W-1:0] ex_rs;
   logic [REG_ADDR_W-1:0] ex_rt;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_regwrite;
   logic                  ex_memread;

   // EX/MEM shadow stage
   logic [REG_ADDR_W-1:0] mem_rd;
   logic                  mem_regwrite;

   // MEM/WB shadow stage
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  wb_regwrite;

   logic                  hazard;
   logic                  take_id;

   // The most recent producer wins: EX/MEM is checked before MEM/WB. A
   // destination of register 0 never forwards.
   function automatic logic [1:0] fwd_select(input logic [REG_ADDR_W-1:0] src);
      logic [1:0] sel;
      sel = SEL_REGFILE;
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))
         sel = SEL_EXMEM;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
         sel = SEL_MEMWB;
      return sel;
   endfunction

   // Load-use detection and stall request; a flush takes priority over the stall
   always_comb begin
      hazard = ex_memread && ex_regwrite && (ex_rd != '0) &&
               ((ex_rd == id_rs_i) || (id_rt_used_i && (ex_rd == id_rt_i)));
      stall_o = hazard && !flush_i;
      take_id = !stall_o && !flush_i;
   end

   // Forward selects for the instruction currently in EX
   always_comb begin
      fwd_a_o = fwd_select(ex_rs);
      fwd_b_o = fwd_select(ex_rt);
   end

   // ID/EX stage: capture the ID instruction, or insert a bubble on stall/flush
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
      end else if (take_id) begin
         ex_rs       <= id_rs_i;
         ex_rt       <= id_rt_i;
         ex_rd       <= id_rd_i;
         ex_regwrite <= id_regwrite_i;
         ex_memread  <= id_memread_i;
      end else begin
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_rd       <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
      end
   end

   // EX/MEM and MEM/WB stages advance unconditionally every cycle
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_rd       <= '0;
         mem_regwrite <= 1'b0;
         wb_rd        <= '0;
         wb_regwrite  <= 1'b0;
      end else begin
         mem_rd       <= ex_rd;
         mem_regwrite <= ex_regwrite;
         wb_rd        <= mem_rd;
         wb_regwrite  <= mem_regwrite;
      end
   end

   // Stall-cycle counter, holding at all-ones instead of wrapping
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         stall_cnt_o <= '0;
      else if (stall_o && (stall_cnt_o != '1))
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
// Directed checks of forwarding selects, load-use stall, flush priority,
// stall counter saturation and asynchronous reset for fwd_hazard_unit.
module tb_fwd_hazard_unit;

   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk_i;
   logic          rst_i;
   logic [AW-1:0] id_rs_i;
   logic [AW-1:0] id_rt_i;
   logic          id_rt_used_i;
   logic [AW-1:0] id_rd_i;
   logic          id_regwrite_i;
   logic          id_memread_i;
   logic          flush_i;
   logic [1:0]    fwd_a_o;
   logic [1:0]    fwd_b_o;
   logic          stall_o;
   logic [CW-1:0] stall_cnt_o;

   int asserts  = 0;
   int failures = 0;

   fwd_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .id_rs_i      (id_rs_i),
      .id_rt_i      (id_rt_i),
      .id_rt_used_i (id_rt_used_i),
      .id_rd_i      (id_rd_i),
      .id_regwrite_i(id_regwrite_i),
      .id_memread_i (id_memread_i),
      .flush_i      (flush_i),
      .fwd_a_o      (fwd_a_o),
      .fwd_b_o      (fwd_b_o),
      .stall_o      (stall_o),
      .stall_cnt_o  (stall_cnt_o)
   );

   // 10 ns clock
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Drive the ID-stage instruction fields
   task automatic drive(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic rt_used, input logic [AW-1:0] rd,
                        input logic rw, input logic mr, input logic fl);
      id_rs_i       = rs;
      id_rt_i       = rt;
      id_rt_used_i  = rt_used;
      id_rd_i       = rd;
      id_regwrite_i = rw;
      id_memread_i  = mr;
      flush_i       = fl;
   endtask

   task automatic drive_nop();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Advance one clock and settle 1 ns past the edge
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Push nops through all shadow stages
   task automatic drain();
      drive_nop();
      repeat (4) step();
   endtask

   task automatic do_reset();
      drive_nop();
      rst_i = 1'b0;
      repeat (2) step();
      rst_i = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      drive(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      repeat (3) step();
      asserts++;
      if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
         $display("[TB] FAIL reset_fwd: a=%0d b=%0d required 0/0", fwd_a_o, fwd_b_o);
         failures++;
      end
      asserts++;
      if (stall_o !== 1'b0 || stall_cnt_o !== 4'd0) begin
         $display("[TB] FAIL reset_stall: stall=%0b cnt=%0d required 0/0", stall_o, stall_cnt_o);
         failures++;
      end
      drive_nop();
      rst_i = 1'b1;
      #1;
      step();
      asserts++;
      if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0 || stall_o !== 1'b0 || stall_cnt_o !== 4'd0) begin
         $display("[TB] FAIL reset_release: a=%0d b=%0d stall=%0b cnt=%0d required all 0",
                  fwd_a_o, fwd_b_o, stall_o, stall_cnt_o);
         failures++;
      end
   endtask

   task automatic test_exmem_fwd();
      drain();
      drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
      step();
      drive(5'd3, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      step();
      drive_nop();
      asserts++;
      if (fwd_a_o !== 2'd2 || fwd_b_o !== 2'd2) begin
         $display("[TB] FAIL exmem_fwd: a=%0d b=%0d required 2/2", fwd_a_o, fwd_b_o);
         failures++;
      end
   endtask

   task automatic test_memwb_fwd();
      drain();
      drive(5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      step();
      drive_nop();
      step();
      drive(5'd4, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      step();
      drive_nop();
      asserts++;
      if (fwd_a_o !== 2'd1 || fwd_b_o !== 2'd0) begin
         $display("[TB] FAIL memwb_fwd: a=%0d b=%0d required 1/0", fwd_a_o, fwd_b_o);
         failures++;
      end
   endtask

   task automatic test_priority();
      drain();
      drive(5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      step();
      drive(5'd8, 5'd9, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      step();
      drive(5'd4, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      step();
      drive_nop();
      asserts++;
      if (fwd_a_o !== 2'd2 || fwd_b_o !== 2'd2) begin
         $display("[TB] FAIL priority_fwd: a=%0d b=%0d required 2/2", fwd_a_o, fwd_b_o);
         failures++;
      end
   endtask

   task automatic test_zero_reg();
      drain();
      drive(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      step();
      asserts++;
      if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
         $display("[TB] FAIL zero_exmem: a=%0d b=%0d required 0/0", fwd_a_o, fwd_b_o);
         failures++;
      end
      drive(5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
      step();
      drive_nop();
      asserts++;
      if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0) begin
         $display("[TB] FAIL zero_memwb: a=%0d b=%0d required 0/0", fwd_a_o, fwd_b_o);
         failures++;
      end
   endtask

   task automatic test_load_use();
      drain();
      drive(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      drive(5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      #1;
      asserts++;
      if (stall_o !== 1'b1 || stall_cnt_o !== 4'd0) begin
         $display("[TB] FAIL loaduse_stall: stall=%0b cnt=%0d required 1/0", stall_o, stall_cnt_o);
         failures++;
      end
      step();
      asserts++;
      if (stall_o !== 1'b0 || stall_cnt_o !== 4'd1) begin
         $display("[TB] FAIL loaduse_release: stall=%0b cnt=%0d required 0/1", stall_o, stall_cnt_o);
         failures++;
      end
      step();
      drive_nop();
      asserts++;
      if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd1) begin
         $display("[TB] FAIL loaduse_fwd: a=%0d b=%0d required 0/1", fwd_a_o, fwd_b_o);
         failures++;
      end
   endtask

   task automatic test_rt_unused();
      drain();
      drive(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      drive(5'd2, 5'd5, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
      #1;
      asserts++;
      if (stall_o !== 1'b0) begin
         $display("[TB] FAIL rt_unused_stall: stall=%0b required 0", stall_o);
         failures++;
      end
      step();
      drive_nop();
      asserts++;
      if (fwd_b_o !== 2'd2 || stall_cnt_o !== 4'd1) begin
         $display("[TB] FAIL rt_unused_next: b=%0d cnt=%0d required 2/1", fwd_b_o, stall_cnt_o);
         failures++;
      end
   endtask

   task automatic test_load_zero();
      drain();
      drive(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      step();
      drive(5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      #1;
      asserts++;
      if (stall_o !== 1'b0) begin
         $display("[TB] FAIL load_zero_stall: stall=%0b required 0", stall_o);
         failures++;
      end
   endtask

   task automatic test_flush_vs_stall();
      drain();
      drive(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      step();
      drive(5'd2, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
      #1;
      asserts++;
      if (stall_o !== 1'b0) begin
         $display("[TB] FAIL flush_stall: stall=%0b required 0", stall_o);
         failures++;
      end
      step();
      drive_nop();
      #1;
      asserts++;
      if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0 || stall_cnt_o !== 4'd1) begin
         $display("[TB] FAIL flush_bubble: a=%0d b=%0d cnt=%0d required 0/0/1",
                  fwd_a_o, fwd_b_o, stall_cnt_o);
         failures++;
      end
   endtask

   task automatic test_saturation();
      do_reset();
      drive(5'd5, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      repeat (24) step();
      asserts++;
      if (stall_cnt_o !== 4'd12) begin
         $display("[TB] FAIL sat_mid: cnt=%0d required 12", stall_cnt_o);
         failures++;
      end
      repeat (16) step();
      asserts++;
      if (stall_cnt_o !== 4'd15) begin
         $display("[TB] FAIL sat_hold: cnt=%0d required 15", stall_cnt_o);
         failures++;
      end
      drain();
   endtask

   task automatic test_reset_midop();
      drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
      step();
      drive(5'd3, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      step();
      asserts++;
      if (fwd_a_o !== 2'd2) begin
         $display("[TB] FAIL midop_pre: a=%0d required 2", fwd_a_o);
         failures++;
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      asserts++;
      if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0 || stall_cnt_o !== 4'd0) begin
         $display("[TB] FAIL midop_reset: a=%0d b=%0d cnt=%0d required 0/0/0",
                  fwd_a_o, fwd_b_o, stall_cnt_o);
         failures++;
      end
      drive_nop();
      step();
      rst_i = 1'b1;
      #1;
      asserts++;
      if (fwd_a_o !== 2'd0 || fwd_b_o !== 2'd0 || stall_o !== 1'b0) begin
         $display("[TB] FAIL midop_release: a=%0d b=%0d stall=%0b required 0/0/0",
                  fwd_a_o, fwd_b_o, stall_o);
         failures++;
      end
   endtask

   // Run every scenario in order and report
   initial begin
      rst_i = 1'b0;
      drive_nop();
      test_reset();
      test_exmem_fwd();
      test_memwb_fwd();
      test_priority();
      test_zero_reg();
      test_load_use();
      test_rt_unused();
      test_load_zero();
      test_flush_vs_stall();
      test_saturation();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
